// File: rtl/intra_neighbour_buffer.sv
// Neighbour pixel buffer for the intra predictor. It walks the frame in raster MB order,
// serves top/left/corner neighbours and captures reconstructed rows as they come back.
module intra_neighbour_buffer #(
  parameter  int WIDTH   = 1280,
  parameter  int LENGTH  = 720,
  parameter  int MB_SIZE = 16,
  parameter  int TOPN    = (MB_SIZE == 4 ? 8 : MB_SIZE),
  parameter  int LEFTN   = (MB_SIZE == 4 ? 5 : MB_SIZE),
  localparam int NCOL    = WIDTH / MB_SIZE,
  localparam int NROW    = LENGTH / MB_SIZE,
  localparam int CW      = (NCOL > 1) ? $clog2(NCOL) : 1,
  localparam int RWD     = (NROW > 1) ? $clog2(NROW) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [TOPN-1:0][7:0]      toppixels,
  output logic [LEFTN-1:0][7:0]     leftpixels,
  output logic                      nb_valid,
  input  logic                      nb_ready,
  input  logic [MB_SIZE-1:0][7:0]   recon_row,
  input  logic                      recon_valid,
  output logic                      recon_ready,
  output logic [CW-1:0]             mb_col,
  output logic [RWD-1:0]            mb_row,
  output logic                      frame_done
);

  localparam int LBW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RCW = $clog2(MB_SIZE);
  localparam int LO  = LEFTN - MB_SIZE;

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, COLLECT, UPDATE} state_t;

  state_t                   r_state, w_next;
  logic [RCW-1:0]           r_row;
  logic [MB_SIZE-1:0][7:0]  r_left;
  logic [7:0]               r_corner;
  logic [7:0]               r_linebuf [WIDTH];
  logic                     w_last_col, w_last_row, w_last_beat;

  function automatic logic [LBW-1:0] lb_idx(input logic [CW-1:0] col, input int c);
    return LBW'(int'(col) * MB_SIZE + c);
  endfunction

  assign w_last_col  = (mb_col == CW'(NCOL - 1));
  assign w_last_row  = (mb_row == RWD'(NROW - 1));
  assign w_last_beat = recon_valid && (r_row == RCW'(MB_SIZE - 1));

  always_comb begin
    w_next      = r_state;
    nb_valid    = 1'b0;
    recon_ready = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   w_next = PRESENT;
      PRESENT: begin
        nb_valid = 1'b1;
        if (nb_ready) w_next = COLLECT;
      end
      COLLECT: begin
        recon_ready = 1'b1;
        if (w_last_beat) w_next = UPDATE;
      end
      UPDATE: begin
        if (w_last_col && w_last_row) begin
          w_next     = IDLE;
          frame_done = 1'b1;
        end else begin
          w_next = FETCH;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      toppixels  <= '0;
      leftpixels <= '0;
      mb_col     <= '0;
      mb_row     <= '0;
      r_row      <= '0;
      r_left     <= {MB_SIZE{8'd128}};
      r_corner   <= 8'd128;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          mb_col <= '0;
          mb_row <= '0;
          r_row  <= '0;
        end
        FETCH: begin
          // Top-right beyond the last column repeats the rightmost top pixel.
          for (int c = 0; c < TOPN; c++) begin
            if (mb_row == '0)
              toppixels[c] <= 8'd128;
            else if (c < MB_SIZE || !w_last_col)
              toppixels[c] <= r_linebuf[lb_idx(mb_col, c)];
            else
              toppixels[c] <= r_linebuf[lb_idx(mb_col, MB_SIZE - 1)];
          end
          for (int r = 0; r < MB_SIZE; r++)
            leftpixels[r + LO] <= (mb_col != '0) ? r_left[r] : 8'd128;
          if (MB_SIZE == 4)
            leftpixels[0] <= (mb_row != '0 && mb_col != '0) ? r_corner : 8'd128;
          // Capture the line-buffer pixel above this MB's right edge before the
          // collect phase overwrites it; it becomes the next MB's corner.
          r_corner <= r_linebuf[lb_idx(mb_col, MB_SIZE - 1)];
        end
        COLLECT: if (recon_valid) begin
          r_left[r_row] <= recon_row[MB_SIZE-1];
          r_row         <= w_last_beat ? '0 : r_row + 1'b1;
        end
        UPDATE: begin
          r_row <= '0;
          if (!w_last_col) begin
            mb_col <= mb_col + 1'b1;
          end else if (!w_last_row) begin
            mb_col <= '0;
            mb_row <= mb_row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer holds only pixel data, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (r_state == COLLECT && w_last_beat)
      for (int c = 0; c < MB_SIZE; c++)
        r_linebuf[lb_idx(mb_col, c)] <= recon_row[c];
  end

endmodule

// File: doc/intra_neighbour_buffer.md
Name: intra_neighbour_buffer

Overview:
Supplies the top/left neighbour pixels consumed by the intra predictor and collects the reconstructed macroblock rows it returns. Tracks raster MB position over a frame. Keeps a one-line buffer of bottom rows, a left-column register and a corner register. Emits neighbour sets in the predictor's layout (4x4: 8 top incl. top-right, 5 left incl. corner at index 0).

Parameters:
WIDTH, 1280, frame width in pixels (multiple of MB_SIZE)
LENGTH, 720, frame height in pixels (multiple of MB_SIZE)
MB_SIZE, 16, block edge in pixels; legal values 4, 8 or 16
TOPN, (MB_SIZE==4 ? 8 : MB_SIZE), derived top-neighbour count
LEFTN, (MB_SIZE==4 ? 5 : MB_SIZE), derived left-neighbour count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins a frame at MB (0,0); ignored unless IDLE
toppixels  out  [7:0] x TOPN  top neighbours; index 0 = leftmost
leftpixels  out  [7:0] x LEFTN  left neighbours; MB_SIZE==4: [0]=corner M, [1..4]=rows 0..3; else [r]=row r
nb_valid  out  1  neighbour set valid, held until nb_ready
nb_ready  in  1  predictor accepts neighbour set
recon_row  in  [7:0] x MB_SIZE  one reconstructed row, index 0 = leftmost
recon_valid  in  1  recon_row valid
recon_ready  out  1  block accepts a row
mb_col  out  $clog2(WIDTH/MB_SIZE)  current MB column
mb_row  out  $clog2(LENGTH/MB_SIZE)  current MB row
frame_done  out  1  one-cycle pulse after last MB's last row

Behaviour:
- Reset (async, any state): state IDLE; toppixels/leftpixels all 0; nb_valid, recon_ready, frame_done 0; mb_col, mb_row, row counter 0; left/corner registers 128. Line buffer contents don't care.
- FSM: IDLE -> FETCH on start; FETCH -> PRESENT (1 cycle); PRESENT -> COLLECT on nb_valid&&nb_ready; COLLECT -> UPDATE when row MB_SIZE-1 accepted; UPDATE -> FETCH if MBs remain, else IDLE with frame_done=1 that cycle.
- FETCH registers outputs:
  - top[c] = linebuf[mb_col*MB_SIZE+c] if mb_row>0, else 128.
  - left[r] = leftreg[r] if mb_col>0, else 128.
  - MB_SIZE==4 top-right top[4..7] = linebuf[mb_col*4+4..7] if mb_row>0 and mb_col<last; if mb_row>0 and mb_col==last, replicate top[3]; if mb_row==0, 128.
  - Corner M = cornerreg if mb_row>0 and mb_col>0, else 128.
  - Same cycle: cornerreg <= linebuf[mb_col*MB_SIZE+MB_SIZE-1] (pre-overwrite value), giving the next MB its corner.
- PRESENT: nb_valid=1; toppixels/leftpixels stable until handshake. nb_valid drops the cycle after the handshake.
- COLLECT: recon_ready=1. Each recon_valid&&recon_ready beat at row r:
  - leftreg[r] <= recon_row[MB_SIZE-1].
  - r==MB_SIZE-1: linebuf[mb_col*MB_SIZE+c] <= recon_row[c] for all c.
  - recon_valid low stalls; no timeout.
- UPDATE: row counter 0; mb_col+1, wrapping to 0 with mb_row+1 at last column; when at last column and last row, go IDLE, no increment; frame_done pulse.
- Latency: nb_valid high 2 cycles after start sampled; 3 cycles after final row handshake for the next MB.
- start during non-IDLE is ignored. start in the same cycle as frame_done is ignored (state still UPDATE).
- Pixel values pass unmodified (8-bit); no arithmetic other than counters.

Test Plan:
- Bench WIDTH=32, LENGTH=32, MB_SIZE=16. Pulse start -> nb_valid 2 cycles later; MB(0,0) top and left all 128; mb_col=0, mb_row=0.
- Feed MB(0,0) rows with pixel(r,c)=r*16+c -> MB(0,1) left[r]=r*16+15, top all 128.
- Feed MB(0,1) pixel=(r*16+c)^8'h55. MB(1,0) top[c]=240+c, left all 128. MB(1,1) top[c]=(240+c)^8'h55, left[r] = MB(1,0) column 15. After last row -> frame_done 1-cycle pulse, state IDLE.
- MB_SIZE=4, WIDTH=8, LENGTH=8: MB(1,1) corner leftpixels[0] = MB(0,0) pixel(3,3). MB(1,1) top[4..7] all equal top[3] (last column replicate). MB(1,0) top[4..7] = MB(0,1) bottom row.
- Hold nb_ready low 5 cycles -> nb_valid stays 1, outputs unchanged, recon_ready 0. recon_valid toggling in COLLECT -> only valid beats counted.
- Assert reset mid-COLLECT (row 7) -> outputs 0 immediately, IDLE. New start -> MB(0,0) with all-128 neighbours.
